dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory of the single-cycle core between two requesters: the core load/store path (core_*) and a debug/loader port (dbg_*).
- Core has default priority. A starvation counter guarantees the debug port is granted after at most MAX_WAIT consecutive lost cycles.
- Sits between Single_Cycle_Top's LSU signals and the data memory. Memory read latency is one cycle; responses are routed back to the requester that owned the read.

---
 rtl/dmem_port_arbiter_if.sv | 72 +++++++
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: core and debug
// requester ports plus the single-port memory side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req,
        input  core_we,
        input  core_addr,
        input  core_wdata,
        output core_gnt,
        output core_rvalid,
        output core_rdata,
        input  dbg_req,
        input  dbg_we,
        input  dbg_addr,
        input  dbg_wdata,
        output dbg_gnt,
        output dbg_rvalid,
        output dbg_rdata,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req,
        output core_we,
        output core_addr,
        output core_wdata,
        input  core_gnt,
        input  core_rvalid,
        input  core_rdata,
        output dbg_req,
        output dbg_we,
        output dbg_addr,
        output dbg_wdata,
        input  dbg_gnt,
        input  dbg_rvalid,
        input  dbg_rdata,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: core has priority,
// debug is guaranteed a grant after MAX_WAIT lost cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    // Width must stay >= 1 even when MAX_WAIT is 0.
    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2
    } owner_t;

    owner_t            rsp_owner;
    owner_t            rsp_next;
    logic [WCW-1:0]    wait_cnt;
    logic [WCW-1:0]    wait_next;
    logic              wait_hit;
    logic              core_sel;
    logic              dbg_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign wait_hit = (wait_cnt == WMAX);

    // Reset gates selection so nothing reaches memory while rst is low.
    always_comb begin
        dbg_sel  = rst & bus.dbg_req & (~bus.core_req | wait_hit);
        core_sel = rst & bus.core_req & ~dbg_sel;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (1'b1)
            dbg_sel: begin
                sel_we    = bus.dbg_we;
                sel_addr  = bus.dbg_addr;
                sel_wdata = bus.dbg_wdata;
            end
            core_sel: begin
                sel_we    = bus.core_we;
                sel_addr  = bus.core_addr;
                sel_wdata = bus.core_wdata;
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    assign bus.core_gnt  = core_sel;
    assign bus.dbg_gnt   = dbg_sel;
    assign bus.mem_en    = core_sel | dbg_sel;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    always_comb begin
        wait_next = '0;
        if (bus.dbg_req && !dbg_sel) begin
            wait_next = wait_hit ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= '0;
            rsp_owner <= NONE;
        end else begin
            wait_cnt  <= wait_next;
            rsp_owner <= rsp_next;
        end
    end

    // Only reads need a return path; writes and idle cycles own nothing.
    always_comb begin
        rsp_next        = NONE;
        bus.core_rvalid = 1'b0;
        bus.core_rdata  = '0;
        bus.dbg_rvalid  = 1'b0;
        bus.dbg_rdata   = '0;

        unique case (1'b1)
            dbg_sel && !bus.dbg_we:   rsp_next = DBG;
            core_sel && !bus.core_we: rsp_next = CORE;
            default:                  rsp_next = NONE;
        endcase

        if (rst) begin
            unique case (rsp_owner)
                CORE: begin
                    bus.core_rvalid = 1'b1;
                    bus.core_rdata  = bus.mem_rdata;
                end
                DBG: begin
                    bus.dbg_rvalid = 1'b1;
                    bus.dbg_rdata  = bus.mem_rdata;
                end
                default: begin
                    bus.core_rvalid = 1'b0;
                    bus.dbg_rvalid  = 1'b0;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (
        @(posedge clk) !(bus.core_gnt && bus.dbg_gnt));
    a_core_gnt_req: assert property (
        @(posedge clk) bus.core_gnt |-> bus.core_req);
    a_dbg_gnt_req: assert property (
        @(posedge clk) bus.dbg_gnt |-> bus.dbg_req);
    a_rvalid_onehot: assert property (
        @(posedge clk) !(bus.core_rvalid && bus.dbg_rvalid));
    a_wait_bound: assert property (
        @(posedge clk) wait_cnt <= WMAX);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_dmem_port_arbiter;
    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [31:0] core_q[$];
    logic [31:0] dbg_q[$];
    logic [31:0] mem[256];

    localparam int EXPW[5] = '{1, 2, 3, 4, 0};

    dmem_port_arbiter_if bus0 ();
    dmem_port_arbiter_if bus1 ();

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)
    ) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)
    ) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    assign bus1.mem_rdata = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory model; preloads 0x10 while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h10] <= 32'hDEADBEEF;
        end else if (bus0.mem_en) begin
            if (bus0.mem_we)
                mem[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
            else
                bus0.mem_rdata <= mem[bus0.mem_addr[7:0]];
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus0.core_rvalid) begin
            if (core_q.size() == 0)
                chk("core_unexp_rvalid", 32'd1, 32'd0);
            else
                chk("core_rdata", bus0.core_rdata, core_q.pop_front());
        end
        if (bus0.dbg_rvalid) begin
            if (dbg_q.size() == 0)
                chk("dbg_unexp_rvalid", 32'd1, 32'd0);
            else
                chk("dbg_rdata", bus0.dbg_rdata, dbg_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.core_req   = 1'b0;
        bus0.core_we    = 1'b0;
        bus0.core_addr  = '0;
        bus0.core_wdata = '0;
        bus0.dbg_req    = 1'b0;
        bus0.dbg_we     = 1'b0;
        bus0.dbg_addr   = '0;
        bus0.dbg_wdata  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle0();
        bus1.core_req   = 1'b0;
        bus1.core_we    = 1'b1;
        bus1.core_addr  = 32'h80;
        bus1.core_wdata = 32'h1;
        bus1.dbg_req    = 1'b0;
        bus1.dbg_we     = 1'b1;
        bus1.dbg_addr   = 32'h84;
        bus1.dbg_wdata  = 32'h2;

        // Reset hold with both ports requesting writes
        bus0.core_req   = 1'b1;
        bus0.core_we    = 1'b1;
        bus0.core_addr  = 32'h40;
        bus0.core_wdata = 32'h1;
        bus0.dbg_req    = 1'b1;
        bus0.dbg_we     = 1'b1;
        bus0.dbg_addr   = 32'h44;
        bus0.dbg_wdata  = 32'h2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {26'd0,
                bus0.core_gnt, bus0.dbg_gnt, bus0.mem_en,
                bus0.mem_we, bus0.core_rvalid, bus0.dbg_rvalid},
                32'd0);
            cyc();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rel_core_gnt", {31'd0, bus0.core_gnt}, 32'd1);
        chk("rel_dbg_gnt", {31'd0, bus0.dbg_gnt}, 32'd0);
        cyc();
        idle0();
        cyc();

        // Core-only read of preloaded word
        bus0.core_req  = 1'b1;
        bus0.core_we   = 1'b0;
        bus0.core_addr = 32'h10;
        core_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("rd_core_gnt", {31'd0, bus0.core_gnt}, 32'd1);
        chk("rd_mem_addr", bus0.mem_addr, 32'h10);
        chk("rd_mem_we", {31'd0, bus0.mem_we}, 32'd0);
        cyc();
        idle0();
        @(negedge clk);
        chk("rd_core_rvalid", {31'd0, bus0.core_rvalid}, 32'd1);
        chk("rd_dbg_rvalid", {31'd0, bus0.dbg_rvalid}, 32'd0);
        chk("idle_mem_en", {31'd0, bus0.mem_en}, 32'd0);
        cyc();

        // Contention: core writes continuously, dbg reads 0x10
        bus0.core_req   = 1'b1;
        bus0.core_we    = 1'b1;
        bus0.core_addr  = 32'h30;
        bus0.core_wdata = 32'h7;
        bus0.dbg_we     = 1'b0;
        bus0.dbg_addr   = 32'h10;
        for (int c = 0; c < 6; c++) begin
            bus0.dbg_req = (c <= 4);
            if (c == 4) dbg_q.push_back(32'hDEADBEEF);
            @(negedge clk);
            chk($sformatf("cont_core_gnt%0d", c),
                {31'd0, bus0.core_gnt}, {31'd0, c != 4});
            chk($sformatf("cont_dbg_gnt%0d", c),
                {31'd0, bus0.dbg_gnt}, {31'd0, c == 4});
            if (c >= 1)
                chk($sformatf("cont_wait%0d", c),
                    32'(u0.wait_cnt), 32'(EXPW[c-1]));
            cyc();
        end
        idle0();
        cyc();

        // Back-to-back: dbg write then core read of same word
        bus0.dbg_req   = 1'b1;
        bus0.dbg_we    = 1'b1;
        bus0.dbg_addr  = 32'h20;
        bus0.dbg_wdata = 32'h55;
        @(negedge clk);
        chk("b2b_dbg_gnt", {31'd0, bus0.dbg_gnt}, 32'd1);
        chk("b2b_wdata", bus0.mem_wdata, 32'h55);
        cyc();
        idle0();
        bus0.core_req  = 1'b1;
        bus0.core_we   = 1'b0;
        bus0.core_addr = 32'h20;
        core_q.push_back(32'h55);
        @(negedge clk);
        chk("b2b_core_gnt", {31'd0, bus0.core_gnt}, 32'd1);
        chk("b2b_no_wr_rvalid", {31'd0, bus0.dbg_rvalid}, 32'd0);
        cyc();
        idle0();
        @(negedge clk);
        chk("b2b_core_rvalid", {31'd0, bus0.core_rvalid}, 32'd1);
        cyc();

        // Reset lands on the cycle after a core read grant
        bus0.core_req  = 1'b1;
        bus0.core_we   = 1'b0;
        bus0.core_addr = 32'h10;
        bus0.dbg_req   = 1'b1;
        bus0.dbg_we    = 1'b0;
        bus0.dbg_addr  = 32'h10;
        @(negedge clk);
        chk("mid_core_gnt", {31'd0, bus0.core_gnt}, 32'd1);
        cyc();
        idle0();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_wait_pre", 32'(u0.wait_cnt), 32'd1);
        chk("mid_rvalid_rst", {31'd0, bus0.core_rvalid}, 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_wait_post", 32'(u0.wait_cnt), 32'd0);
        chk("mid_rvalid_post", {31'd0, bus0.core_rvalid}, 32'd0);
        cyc();

        // MAX_WAIT=0 build: dbg always wins
        bus1.core_req = 1'b1;
        bus1.dbg_req  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mw0_dbg_gnt%0d", c),
                {31'd0, bus1.dbg_gnt}, 32'd1);
            chk($sformatf("mw0_core_gnt%0d", c),
                {31'd0, bus1.core_gnt}, 32'd0);
            cyc();
        end
        bus1.core_req = 1'b0;
        bus1.dbg_req  = 1'b0;
        cyc();
        @(negedge clk);

        chk("core_q_empty", 32'(core_q.size()), 32'd0);
        chk("dbg_q_empty", 32'(dbg_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want done");
        $fatal(1, "timeout");
    end
endmodule
